i2s_audio_tx: RTL and testbench
===============================

I2S_AUDIO_TX -- requirements
Module: i2s_audio_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 10, meaning system clocks per BCK half-period; legal range 1..255.
REQ-002 SHALL have port clk32  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port left_in  input  16  signed two's-complement left sample.
REQ-005 SHALL have port right_in  input  16  signed two's-complement right sample.
REQ-006 SHALL have port sample_req  output  1  one-clk32 pulse marking the cycle left_in/right_in are captured.
REQ-007 SHALL have port I2S_BCK  output  1  bit clock.
REQ-008 SHALL have port I2S_LRCK  output  1  word select; 0 = left, 1 = right.
REQ-009 SHALL have port I2S_DATA  output  1  serial data, MSB first.

Function
REQ-010 SHALL run a divider counter 0..CLK_DIV-1 that wraps; each wrap toggles I2S_BCK, giving a BCK period of 2*CLK_DIV clk32 cycles.
REQ-011 SHALL treat a wrap with I2S_BCK=1 as a BCK falling event; all changes to I2S_DATA, I2S_LRCK and the bit counter occur only on falling events.
REQ-012 SHALL keep a 5-bit bit counter n that increments modulo 32 on each falling event, giving 32 BCK per frame, 16 per channel slot.
REQ-013 SHALL drive I2S_LRCK=0 while n is 31 or 0..14, and 1 while n is 15..30, so LRCK changes one BCK before each slot's MSB (standard I2S).
REQ-014 SHALL, on the falling event where n wraps 31->0, load a 32-bit shift register with {left_in, right_in} and assert sample_req for exactly that clk32 cycle.
REQ-015 SHALL drive I2S_DATA from shift register bit 31; on every other falling event it SHALL shift left by one and fill with 0.
REQ-016 SHALL make I2S_DATA equal left_in[15-n] for n=0..15 and right_in[31-n] for n=16..31, using values captured at load.
REQ-017 SHALL ignore input changes outside the load cycle; mid-frame changes never affect the current frame.
REQ-018 SHALL produce Fs = f(clk32)/(64*CLK_DIV); CLK_DIV=10 at 32 MHz gives 50 kHz.
REQ-019 SHALL handle CLK_DIV=1 with the divider wrapping every cycle, so BCK toggles every clk32.

Reset
REQ-020 SHALL, while reset=1, force I2S_BCK=0, I2S_LRCK=0, I2S_DATA=0, sample_req=0, divider=0, n=31, shift register=0.
REQ-021 SHALL make the first falling event after reset release the 31->0 load: the first rising edge is at cycle CLK_DIV and the first falling event at cycle 2*CLK_DIV.
REQ-022 SHALL abort an in-progress frame when reset asserts mid-frame, with no partial sample completed afterward.

Structure
REQ-023 SHALL place SLOT_BITS=16 and FRAME_BITS=32 in shared package c64_audio_pkg.
REQ-024 SHALL factor the divider and BCK toggle into sub-module i2s_bck_gen, with outputs bck, rise_en and fall_en.
REQ-025 SHALL be fully registered; no output depends combinationally on inputs.

Verification
REQ-026 CLK_DIV=2, left=16'h8001, right=16'h7FFE -> bits 1,0x14,1 in left slot, then 0,1x14,0 in right slot; BCK period 4 clk32.
REQ-027 Reset release -> sample_req pulses once 4 clk32 (2*CLK_DIV) cycles after release, then every 128 cycles; LRCK falls one BCK before each left MSB.
REQ-028 left_in changed mid left slot -> current frame's serial data unchanged; new value appears in the next frame.
REQ-029 CLK_DIV=1 -> BCK toggles every clk32; frame = 64 clk32; data stable across each BCK rising edge.
REQ-030 Reset asserted at n=20 for 3 cycles -> outputs 0 during reset; restart per REQ-021; no stray sample_req.
REQ-031 CLK_DIV=10 over 1 ms at 32 MHz -> exactly 50 sample_req pulses.

Source files
------------

// File: rtl/c64_audio_pkg.sv
// Shared constants and types for the I2S audio transmitter: frame geometry,
// slot encoding and the helper that maps a bit position onto its LRCK slot.
package c64_audio_pkg;

  localparam int SLOT_BITS  = 16;
  localparam int FRAME_BITS = 32;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = 8;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  typedef struct packed {
    logic [SLOT_BITS-1:0] left;
    logic [SLOT_BITS-1:0] right;
  } frame_t;

  localparam logic [CNT_W-1:0] RIGHT_FIRST = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] RIGHT_LAST  = CNT_W'(FRAME_BITS - 2);
  localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_BITS - 1);

  // Word select leads the data by one BCK, so the right slot spans n = 15..30.
  function automatic chan_e slot_of(input logic [CNT_W-1:0] n);
    if ((n >= RIGHT_FIRST) && (n <= RIGHT_LAST)) begin
      return CH_RIGHT;
    end
    return CH_LEFT;
  endfunction

endpackage

// File: rtl/i2s_audio_tx_if.sv
// Bit-clock bundle between the BCK generator and the serializer.
// rise_en/fall_en are one-cycle strobes, high in the clk cycle whose closing edge toggles bck.
interface i2s_audio_tx_if;

  logic bck;
  logic rise_en;
  logic fall_en;

  modport master (
    output bck,
    output rise_en,
    output fall_en
  );

  modport slave (
    input bck,
    input rise_en,
    input fall_en
  );

endinterface

// File: rtl/i2s_bck_gen.sv
// Bit-clock generator: a 0..CLK_DIV-1 divider whose wrap toggles BCK and
// announces the coming rising or falling edge one cycle ahead.
module i2s_bck_gen
  import c64_audio_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic           clk_i,
  input  logic           rst_i,
  i2s_audio_tx_if.master bck_if
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bck_q, bck_d;
  logic             wrap;

  always_comb begin
    wrap  = (div_q == DIV_LAST);
    div_d = div_q + DIV_W'(1);
    bck_d = bck_q;
    if (wrap) begin
      div_d = '0;
      bck_d = ~bck_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      bck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      bck_q <= bck_d;
    end
  end

  assign bck_if.bck     = bck_q;
  assign bck_if.rise_en = wrap & ~bck_q;
  assign bck_if.fall_en = wrap & bck_q;

endmodule

// File: rtl/i2s_audio_tx.sv
// Stereo I2S transmitter: captures a 16-bit left/right pair once per 32-BCK
// frame and shifts it out MSB first, with LRCK leading each slot by one BCK.
module i2s_audio_tx
  import c64_audio_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic                 clk32,
  input  logic                 reset,
  input  logic [SLOT_BITS-1:0] left_in,
  input  logic [SLOT_BITS-1:0] right_in,
  output logic                 sample_req,
  output logic                 I2S_BCK,
  output logic                 I2S_LRCK,
  output logic                 I2S_DATA
);

  i2s_audio_tx_if bck_bus ();

  i2s_bck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_bck_gen (
    .clk_i (clk32),
    .rst_i (reset),
    .bck_if(bck_bus)
  );

  logic [CNT_W-1:0] n_q, n_d;
  frame_t           shreg_q, shreg_d;
  chan_e            lrck_q, lrck_d;
  logic             req_q, req_d;
  logic             unused_rise;

  // The serializer only acts on falling edges; the rise strobe is not needed here.
  assign unused_rise = bck_bus.rise_en;

  always_comb begin
    n_d     = n_q;
    shreg_d = shreg_q;
    lrck_d  = lrck_q;
    req_d   = 1'b0;
    if (bck_bus.fall_en) begin
      n_d    = n_q + CNT_W'(1);
      lrck_d = slot_of(n_d);
      if (n_q == FRAME_LAST) begin
        shreg_d = {left_in, right_in};
        req_d   = 1'b1;
      end else begin
        shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      n_q     <= FRAME_LAST;
      shreg_q <= '0;
      lrck_q  <= CH_LEFT;
      req_q   <= 1'b0;
    end else begin
      n_q     <= n_d;
      shreg_q <= shreg_d;
      lrck_q  <= lrck_d;
      req_q   <= req_d;
    end
  end

  assign sample_req = req_q;
  assign I2S_BCK    = bck_bus.bck;
  assign I2S_LRCK   = lrck_q;
  assign I2S_DATA   = shreg_q[FRAME_BITS-1];

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Bench for i2s_audio_tx: serial-frame scoreboard on a CLK_DIV=2 instance,
// plus timing checks on CLK_DIV=1, CLK_DIV=10 and a standalone BCK generator.
module tb_i2s_audio_tx;
  import c64_audio_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_g = 1'b1;
  logic [15:0] l_a = '0, r_a = '0, l_b = 16'hC3A5, r_b = 16'h5A3C, l_c = 16'h1357, r_c = 16'h2468;
  logic        req_a, bck_a, lrck_a, data_a;
  logic        req_b, bck_b, lrck_b, data_b;
  logic        req_c, bck_c, lrck_c, data_c;

  i2s_audio_tx #(.CLK_DIV(2)) u_dut_a (
    .clk32(clk), .reset(rst_a), .left_in(l_a), .right_in(r_a),
    .sample_req(req_a), .I2S_BCK(bck_a), .I2S_LRCK(lrck_a), .I2S_DATA(data_a)
  );
  i2s_audio_tx #(.CLK_DIV(1)) u_dut_b (
    .clk32(clk), .reset(rst_b), .left_in(l_b), .right_in(r_b),
    .sample_req(req_b), .I2S_BCK(bck_b), .I2S_LRCK(lrck_b), .I2S_DATA(data_b)
  );
  i2s_audio_tx #(.CLK_DIV(10)) u_dut_c (
    .clk32(clk), .reset(rst_c), .left_in(l_c), .right_in(r_c),
    .sample_req(req_c), .I2S_BCK(bck_c), .I2S_LRCK(lrck_c), .I2S_DATA(data_c)
  );

  i2s_audio_tx_if gen_if ();
  i2s_bck_gen #(.CLK_DIV(3)) u_gen (.clk_i(clk), .rst_i(rst_g), .bck_if(gen_if));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard for instance A ----------------
  logic [31:0] exp_q[$];
  logic [31:0] lat_a;
  logic        prev_bck_a = 1'b0, prev_lrck_a = 1'b1, coll_a = 1'b0, lrck_bad_a = 1'b0;
  int          cnt_a = 0, done_a = 0;
  logic [31:0] sh_a = '0, last_frame_a = '0, head_a;

  always @(posedge clk) lat_a <= {l_a, r_a};

  initial begin
    forever begin
      @(negedge clk);
      if (rst_a) begin
        exp_q.delete();
        coll_a      = 1'b0;
        cnt_a       = 0;
        lrck_bad_a  = 1'b0;
        prev_lrck_a = 1'b1;
      end else begin
        if (req_a === 1'b1) exp_q.push_back(lat_a);
        if (bck_a && !prev_bck_a) begin
          if (coll_a) begin
            if (lrck_a !== ((cnt_a >= 15 && cnt_a <= 30) ? 1'b1 : 1'b0)) lrck_bad_a = 1'b1;
            sh_a = {sh_a[30:0], data_a};
            cnt_a++;
            if (cnt_a == 32) begin
              check("frame_q_nonempty", (exp_q.size() != 0), 1);
              if (exp_q.size() != 0) begin
                head_a = exp_q.pop_front();
                check("frame_data", sh_a, head_a);
              end
              check("frame_lrck", lrck_bad_a, 0);
              last_frame_a = sh_a;
              done_a++;
              coll_a     = 1'b0;
              lrck_bad_a = 1'b0;
            end
          end
          if (prev_lrck_a && !lrck_a) begin
            coll_a     = 1'b1;
            cnt_a      = 0;
            lrck_bad_a = 1'b0;
          end
          prev_lrck_a = lrck_a;
        end
      end
      prev_bck_a = bck_a;
    end
  end

  // ---------------- driver / wait tasks ----------------
  task automatic cycles_to_req_a(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk); #1;
      if (req_a === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic wait_req_a(input string name);
    int cyc;
    cycles_to_req_a(cyc);
    check(name, (cyc != 0), 1);
  endtask

  task automatic wait_done_a(input int target, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (done_a >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [31:0] exp;
  } vec_t;
  vec_t        vecs[8];
  int          cyc, d0, tog_err, stab_err, nb, pulses, first_c, rise_n, fall_n;
  int          reqs_b[$];
  logic        pb, pd;
  logic [31:0] sh_b;

  initial begin
    vecs[0] = '{16'h0000, 16'h0000, 32'h0000_0000};
    vecs[1] = '{16'hFFFF, 16'h0000, 32'hFFFF_0000};
    vecs[2] = '{16'hAAAA, 16'h5555, 32'hAAAA_5555};
    vecs[3] = '{16'h8000, 16'h0001, 32'h8000_0001};
    vecs[4] = '{16'h1234, 16'hABCD, 32'h1234_ABCD};
    for (int i = 5; i < 8; i++) begin
      vecs[i].l   = 16'($urandom_range(0, 65535));
      vecs[i].r   = 16'($urandom_range(0, 65535));
      vecs[i].exp = {vecs[i].l, vecs[i].r};
    end

    repeat (3) @(negedge clk);
    #1;
    check("reset_outs_a", {req_a, bck_a, lrck_a, data_a}, 4'h0);
    check("reset_outs_b", {req_b, bck_b, lrck_b, data_b}, 4'h0);
    check("reset_outs_c", {req_c, bck_c, lrck_c, data_c}, 4'h0);

    // Release with the 8001/7FFE pattern; first load at 2*CLK_DIV, then every 128.
    l_a   = 16'h8001;
    r_a   = 16'h7FFE;
    rst_a = 1'b0;
    cycles_to_req_a(cyc);
    check("first_req_cycle", cyc, 4);
    cycles_to_req_a(cyc);
    check("req_period", cyc, 128);
    check("frame_8001_7ffe", last_frame_a, 32'h8001_7FFE);

    for (int i = 0; i < 8; i++) begin
      l_a = vecs[i].l;
      r_a = vecs[i].r;
      wait_req_a("vec_req_timeout");
      d0 = done_a;
      wait_done_a(d0 + 1, "vec_done_timeout");
      check($sformatf("vec%0d", i), last_frame_a, vecs[i].exp);
    end

    // Mid-slot input change must only show up in the following frame.
    l_a = 16'h1111;
    r_a = 16'h2222;
    wait_req_a("mid_req_timeout");
    repeat (20) @(negedge clk);
    l_a = 16'hBEEF;
    d0  = done_a;
    wait_done_a(d0 + 1, "mid_done1_timeout");
    check("mid_frame_old", last_frame_a, 32'h1111_2222);
    wait_done_a(d0 + 2, "mid_done2_timeout");
    check("mid_frame_new", last_frame_a, 32'hBEEF_2222);

    // Reset at n=20 for three cycles, then a clean restart.
    l_a = 16'h0F0F;
    r_a = 16'hF00F;
    wait_req_a("rst_req_timeout");
    repeat (80) @(negedge clk);
    #1;
    rst_a = 1'b1;
    @(negedge clk); #1;
    check("mid_reset_outs", {req_a, bck_a, lrck_a, data_a}, 4'h0);
    repeat (2) @(negedge clk);
    #1;
    check("mid_reset_hold", {req_a, bck_a, lrck_a, data_a}, 4'h0);
    rst_a = 1'b0;
    cycles_to_req_a(cyc);
    check("restart_req_cycle", cyc, 4);
    d0 = done_a;
    wait_done_a(d0 + 1, "restart_done_timeout");
    check("restart_frame", last_frame_a, 32'h0F0F_F00F);

    // CLK_DIV=1: BCK toggles every cycle, data only moves on falling edges.
    tog_err  = 0;
    stab_err = 0;
    nb       = 0;
    sh_b     = '0;
    pb       = bck_b;
    pd       = data_b;
    rst_b    = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk); #1;
      if (bck_b === pb) tog_err++;
      if (bck_b && (data_b !== pd)) stab_err++;
      if (bck_b && reqs_b.size() != 0 && nb < 32) begin
        sh_b = {sh_b[30:0], data_b};
        nb++;
      end
      if (req_b === 1'b1) reqs_b.push_back(k);
      pb = bck_b;
      pd = data_b;
    end
    check("b_toggle_errs", tog_err, 0);
    check("b_stable_errs", stab_err, 0);
    check("b_req_count", reqs_b.size(), 4);
    if (reqs_b.size() >= 2) begin
      check("b_first_req", reqs_b[0], 2);
      check("b_req_period", reqs_b[1] - reqs_b[0], 64);
    end
    check("b_frame", sh_b, {l_b, r_b});

    // CLK_DIV=10: 32000 cycles is 1 ms at 32 MHz.
    pulses  = 0;
    first_c = 0;
    rst_c   = 1'b0;
    for (int k = 1; k <= 32000; k++) begin
      @(negedge clk); #1;
      if (req_c === 1'b1) begin
        pulses++;
        if (first_c == 0) first_c = k;
      end
    end
    check("c_req_count_1ms", pulses, 50);
    check("c_first_req", first_c, 20);

    // Standalone generator, CLK_DIV=3: one rise and one fall strobe every 6 cycles.
    rise_n = 0;
    fall_n = 0;
    rst_g  = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk); #1;
      if (gen_if.rise_en === 1'b1) rise_n++;
      if (gen_if.fall_en === 1'b1) fall_n++;
    end
    check("gen_rise_count", rise_n, 10);
    check("gen_fall_count", fall_n, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
